switch_conditioner: RTL

Conditions the raw slide switches before they reach the 7-segment scroller/display controller. Each channel passes through a 2-flop synchronizer and a per-channel debounce counter. Each channel produces a clean level, single-cycle rise/fall pulses and a rise-toggled state. The scroller consumes sw_level, or sw_toggle, as its switch_1..switch_4 inputs.

---
 rtl/switch_conditioner.sv | 73 +++++++
 1 files changed

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - slide switch synchronizer, debouncer and edge/toggle generator
module switch_conditioner #(
   parameter int NUM_SW          = 4,
   parameter int CNT_WIDTH       = 20,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_SW-1:0] sw_raw,
   output logic [NUM_SW-1:0] sw_level,
   output logic [NUM_SW-1:0] sw_rise,
   output logic [NUM_SW-1:0] sw_fall,
   output logic [NUM_SW-1:0] sw_toggle,
   output logic              any_change
);

   // Last count value before a change is accepted; the counter never exceeds it.
   localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0]    sync1;
   logic [NUM_SW-1:0]    sync2;
   logic [CNT_WIDTH-1:0] cnt [NUM_SW];

   // Two-flop synchronizer; only sync2 is used by the debounce logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   // Per-channel debounce: a change is accepted only after DEBOUNCE_CYCLES
   // consecutive mismatching samples; any matching sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_level  <= '0;
         sw_rise   <= '0;
         sw_fall   <= '0;
         sw_toggle <= '0;
         for (int i = 0; i < NUM_SW; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sw_rise <= '0;
         sw_fall <= '0;
         for (int i = 0; i < NUM_SW; i++) begin
            if (sync2[i] == sw_level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == TERM_CNT) begin
               cnt[i]      <= '0;
               sw_level[i] <= sync2[i];
               if (sync2[i]) begin
                  sw_rise[i]   <= 1'b1;
                  sw_toggle[i] <= ~sw_toggle[i];
               end else begin
                  sw_fall[i] <= 1'b1;
               end
            end else begin
               cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   // Combinational summary of this cycle's registered pulses.
   always_comb begin
      any_change = |(sw_rise | sw_fall);
   end

endmodule
